// File: rtl/noise_pkg.sv
// Shared types and constants for the noise sample scheduler.
package noise_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      CAPTURE = 2'd2
   } noise_state_e;

   // Modulo reduction for values known to lie in [0, 2*n).
   function automatic int rr_wrap(int v, int n);
      return (v >= n) ? (v - n) : v;
   endfunction

endpackage

// File: rtl/noise_sched_if.sv
// Voice/LFSR side bundle of the noise scheduler; slave is the scheduler end.
interface noise_sched_if
   import noise_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic              audio_clk_en;
   logic [NREQ-1:0]   req;
   logic [LFSR_W-1:0] lfsr_q;
   logic              lfsr_step;
   logic [LFSR_W-1:0] sample;
   logic [IDW-1:0]    sample_id;
   logic              sample_valid;
   logic              busy;
   logic [NREQ-1:0]   pend;

   modport master (
      output audio_clk_en, req, lfsr_q,
      input  lfsr_step, sample, sample_id, sample_valid, busy, pend
   );

   modport slave (
      input  audio_clk_en, req, lfsr_q,
      output lfsr_step, sample, sample_id, sample_valid, busy, pend
   );

endinterface

// File: rtl/noise_sched_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or after ptr, wrapping at NREQ.
module rr_pick
   import noise_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_pend,
   input  logic [IDW-1:0]  i_ptr,
   output logic            o_any,
   output logic [IDW-1:0]  o_idx
);

   function automatic logic [IDW-1:0] cand_idx(logic [IDW-1:0] ptr, int k);
      int s;
      s = rr_wrap(int'(ptr) + k, NREQ);
      return s[IDW-1:0];
   endfunction

   // Walk from the farthest candidate back to ptr so the nearest hit is written last.
   always_comb begin
      o_any = |i_pend;
      o_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_pend[cand_idx(i_ptr, k)]) o_idx = cand_idx(i_ptr, k);
      end
   end

endmodule

// File: rtl/noise_sched.sv
// Round-robin sharing of one noise LFSR among NREQ voices, one step per accepted audio tick.
// Optional NOISE_FREERUN_EN: idle ticks still step the LFSR without producing a sample.
//
// state   | meaning
// IDLE    | waiting for audio tick with a pending request (or any tick in free-run)
// STEP    | lfsr_step high; LFSR advances at end of cycle
// CAPTURE | new lfsr_q available; sample registered, pend bit cleared, ptr advanced
module noise_sched
   import noise_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic         clk,
   input  logic         I_RSTn,
   noise_sched_if.slave bus
);

   localparam int IDW = $clog2(NREQ);

`ifdef NOISE_FREERUN_EN
   localparam bit FREERUN = 1'b1;
`else
   localparam bit FREERUN = 1'b0;
`endif

   noise_state_e      r_state;
   noise_state_e      w_state_nxt;
   logic              w_start;

   logic [NREQ-1:0]   r_pend;
   logic [NREQ-1:0]   w_pend_nxt;
   logic [IDW-1:0]    r_ptr;
   logic [IDW-1:0]    r_gnt_idx;
   logic [IDW-1:0]    w_gnt_inc;
   logic              r_gnt_live;
   logic              w_capture_live;

   logic              w_pick_any;
   logic [IDW-1:0]    w_pick_idx;

   logic [LFSR_W-1:0] r_sample;
   logic [IDW-1:0]    r_sample_id;
   logic              r_sample_valid;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .i_pend (r_pend),
      .i_ptr  (r_ptr),
      .o_any  (w_pick_any),
      .o_idx  (w_pick_idx)
   );

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.audio_clk_en && (w_pick_any || FREERUN)) begin
               w_state_nxt = STEP;
               w_start     = 1'b1;
            end
         end
         STEP:    w_state_nxt = CAPTURE;
         CAPTURE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A free-run pass (no grant) must not touch pend, ptr or the sample outputs.
   assign w_capture_live = (r_state == CAPTURE) && r_gnt_live;
   assign w_gnt_inc      = (r_gnt_idx == IDW'(NREQ - 1)) ? '0 : r_gnt_idx + IDW'(1);

   // New requests are ORed in after the clear, so a coincident re-request survives.
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_capture_live) w_pend_nxt[r_gnt_idx] = 1'b0;
      w_pend_nxt = w_pend_nxt | bus.req;
   end

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         r_pend         <= '0;
         r_ptr          <= '0;
         r_gnt_idx      <= '0;
         r_gnt_live     <= 1'b0;
         r_sample       <= '0;
         r_sample_id    <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_pend         <= w_pend_nxt;
         r_sample_valid <= w_capture_live;
         if (w_start) begin
            r_gnt_live <= w_pick_any;
            if (w_pick_any) r_gnt_idx <= w_pick_idx;
         end
         if (w_capture_live) begin
            r_sample    <= bus.lfsr_q;
            r_sample_id <= r_gnt_idx;
            r_ptr       <= w_gnt_inc;
         end
      end
   end

   assign bus.lfsr_step    = (r_state == STEP);
   assign bus.busy         = (r_state != IDLE);
   assign bus.sample       = r_sample;
   assign bus.sample_id    = r_sample_id;
   assign bus.sample_valid = r_sample_valid;
   assign bus.pend         = r_pend;

endmodule

// File: tb/tb_noise_sched.sv
// Directed bench for noise_sched with a local 8-bit Galois LFSR (poly 0x1D, seed 0xFF).
module tb_noise_sched;
   import noise_pkg::*;

   localparam int NREQ = 4;

`ifdef NOISE_FREERUN_EN
   localparam int          EXP_IDLE_STEPS = 1;
   localparam logic [7:0]  EXP_FIRST      = 8'hDB;
`else
   localparam int          EXP_IDLE_STEPS = 0;
   localparam logic [7:0]  EXP_FIRST      = 8'hE3;
`endif

   logic clk    = 1'b0;
   logic I_RSTn = 1'b1;
   always #5 clk = ~clk;

   noise_sched_if #(.NREQ(NREQ)) u_if ();

   noise_sched #(.NREQ(NREQ)) u_dut (
      .clk    (clk),
      .I_RSTn (I_RSTn),
      .bus    (u_if.slave)
   );

   logic [7:0] r_lfsr;
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn)             r_lfsr <= LFSR_SEED;
      else if (u_if.lfsr_step) r_lfsr <= {r_lfsr[6:0], 1'b0} ^ (r_lfsr[7] ? 8'h1D : 8'h00);
   end
   assign u_if.lfsr_q = r_lfsr;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_step   = 0;
   int   n_valid  = 0;
   int   n_step_dbl = 0;
   logic prev_step  = 1'b0;
   int   s0, v0;

   always @(posedge clk) begin
      #1;
      if (u_if.lfsr_step) begin
         n_step++;
         if (prev_step) n_step_dbl++;
      end
      if (u_if.sample_valid) n_valid++;
      prev_step = u_if.lfsr_step;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      I_RSTn            = 1'b0;
      u_if.audio_clk_en = 1'b0;
      u_if.req          = '0;
      repeat (2) @(negedge clk);
      I_RSTn = 1'b1;
   endtask

   task automatic pulse_req(logic [NREQ-1:0] v);
      @(negedge clk);
      u_if.req = v;
      @(negedge clk);
      u_if.req = '0;
   endtask

   // One tick at T; checks step at T+1, idle step at T+2, sample at T+3, idle at T+4.
   task automatic service(string tag, logic [NREQ-1:0] hold_req, int exp_id,
                          logic [7:0] exp_smp, logic [NREQ-1:0] exp_pend);
      @(negedge clk);
      u_if.audio_clk_en = 1'b1;
      u_if.req          = hold_req;
      @(negedge clk);
      u_if.audio_clk_en = 1'b0;
      chk({tag, "_step"}, u_if.lfsr_step, 1);
      chk({tag, "_busy"}, u_if.busy, 1);
      @(negedge clk);
      chk({tag, "_step_off"}, u_if.lfsr_step, 0);
      @(negedge clk);
      u_if.req = '0;
      chk({tag, "_valid"}, u_if.sample_valid, 1);
      chk({tag, "_id"}, u_if.sample_id, exp_id);
      chk({tag, "_sample"}, u_if.sample, exp_smp);
      chk({tag, "_pend"}, u_if.pend, exp_pend);
      @(negedge clk);
      chk({tag, "_valid_off"}, u_if.sample_valid, 0);
      chk({tag, "_idle"}, u_if.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.audio_clk_en = 1'b0;
      u_if.req          = '0;
      #1 I_RSTn = 1'b0;
      #2;
      chk("rst_step",  u_if.lfsr_step, 0);
      chk("rst_busy",  u_if.busy, 0);
      chk("rst_valid", u_if.sample_valid, 0);
      chk("rst_sample", u_if.sample, 8'h00);
      chk("rst_id",    u_if.sample_id, 0);
      chk("rst_pend",  u_if.pend, 0);
      repeat (2) @(negedge clk);
      I_RSTn = 1'b1;

      pulse_req(4'b0100);
      chk("pend_cap", u_if.pend, 4'b0100);
      service("single", 4'b0000, 2, 8'hE3, 4'b0000);

      do_reset();
      pulse_req(4'b1011);
      service("rr0", 4'b0000, 0, 8'hE3, 4'b1010);
      repeat (3) @(negedge clk);
      service("rr1", 4'b0000, 1, 8'hDB, 4'b1000);
      repeat (3) @(negedge clk);
      service("rr3", 4'b0000, 3, 8'hAB, 4'b0000);

      // Tick held through STEP and CAPTURE: only one step and one sample.
      pulse_req(4'b1111);
      s0 = n_step;
      v0 = n_valid;
      @(negedge clk);
      u_if.audio_clk_en = 1'b1;
      repeat (3) @(negedge clk);
      u_if.audio_clk_en = 1'b0;
      chk("hold_tick_valid", u_if.sample_valid, 1);
      chk("hold_tick_id", u_if.sample_id, 0);
      chk("hold_tick_sample", u_if.sample, 8'h4B);
      repeat (4) @(negedge clk);
      chk("hold_tick_nstep", n_step - s0, 1);
      chk("hold_tick_nvalid", n_valid - v0, 1);
      chk("hold_tick_pend", u_if.pend, 4'b1110);

      service("req1_held", 4'b0010, 1, 8'h96, 4'b1110);
      service("after_hold2", 4'b0000, 2, 8'h31, 4'b1010);
      service("after_hold3", 4'b0000, 3, 8'h62, 4'b0010);
      service("back_to1", 4'b0000, 1, 8'hC4, 4'b0000);

      // Reset asserted while in STEP.
      pulse_req(4'b0001);
      @(negedge clk);
      u_if.audio_clk_en = 1'b1;
      @(negedge clk);
      u_if.audio_clk_en = 1'b0;
      chk("pre_rst_step", u_if.lfsr_step, 1);
      I_RSTn = 1'b0;
      #1;
      chk("midrst_step", u_if.lfsr_step, 0);
      chk("midrst_busy", u_if.busy, 0);
      chk("midrst_pend", u_if.pend, 0);
      chk("midrst_sample", u_if.sample, 8'h00);
      chk("midrst_id", u_if.sample_id, 0);
      chk("midrst_valid", u_if.sample_valid, 0);
      @(negedge clk);
      I_RSTn = 1'b1;
      v0 = n_valid;
      repeat (6) @(negedge clk);
      chk("post_rst_nvalid", n_valid - v0, 0);

      // Idle tick with nothing pending.
      s0 = n_step;
      v0 = n_valid;
      @(negedge clk);
      u_if.audio_clk_en = 1'b1;
      @(negedge clk);
      u_if.audio_clk_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_nstep", n_step - s0, EXP_IDLE_STEPS);
      chk("idle_nvalid", n_valid - v0, 0);
      chk("idle_pend", u_if.pend, 0);
      pulse_req(4'b0001);
      service("after_idle", 4'b0000, 0, EXP_FIRST, 4'b0000);

      chk("step_never_double", n_step_dbl, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
